// File: rtl/hex_display_ctrl.sv
// Time-multiplexed hex-to-seven-segment sequencer with shadow commit.
// Optional leading-zero blanking via HEX_LEAD_ZERO_BLANK_EN.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_value,
    input  logic                    in_blank,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    busy,
    output logic                    update_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [4*NUM_DIGITS-1:0]   lat_value;
    logic                      lat_blank;
    logic [7*NUM_DIGITS-1:0]   shadow;
    logic [3:0]                nib;
    logic [6:0]                seg;
`ifdef HEX_LEAD_ZERO_BLANK_EN
    logic                      seen_nz;
`endif

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0011000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        nib = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) nib = lat_value[4*k +: 4];
        end
    end

    always_comb begin
        seg = decode(nib);
        if (lat_blank) begin
            seg = SEG_BLANK;
        end
`ifdef HEX_LEAD_ZERO_BLANK_EN
        // digit 0 is never blanked so a zero value still shows "0"
        else if (idx != '0 && nib == 4'h0 && !seen_nz) begin
            seg = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            idx         <= '0;
            lat_value   <= '0;
            lat_blank   <= 1'b0;
            shadow      <= '0;
            hex_out     <= '1;
            update_done <= 1'b0;
`ifdef HEX_LEAD_ZERO_BLANK_EN
            seen_nz     <= 1'b0;
`endif
        end else begin
            update_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        lat_value <= in_value;
                        lat_blank <= in_blank;
                        idx       <= LAST_IDX;
`ifdef HEX_LEAD_ZERO_BLANK_EN
                        seen_nz   <= 1'b0;
`endif
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (idx == IDX_W'(k)) shadow[7*k +: 7] <= seg;
                    end
`ifdef HEX_LEAD_ZERO_BLANK_EN
                    if (nib != 4'h0) seen_nz <= 1'b1;
`endif
                    if (idx == '0) state <= COMMIT;
                    else           idx   <= idx - IDX_W'(1);
                end
                COMMIT: begin
                    hex_out     <= shadow;
                    update_done <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed scoreboard bench for hex_display_ctrl.
// Expected display images are queued at acceptance and popped at commit.
module tb_hex_display_ctrl;

    localparam int N = 6;
    localparam int W = 7 * N;
    localparam logic [W-1:0] DARK = '1;
`ifdef HEX_LEAD_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [4*N-1:0] in_value = '0;
    logic           in_blank = 1'b0;
    logic [W-1:0]   hex_out;
    logic           busy;
    logic           update_done;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] shown;
    int waited;

    hex_display_ctrl #(.NUM_DIGITS(N)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .in_blank    (in_blank),
        .hex_out     (hex_out),
        .busy        (busy),
        .update_done (update_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [4*N-1:0] v,
                                           input logic b);
        logic [W-1:0] r;
        logic seen;
        logic [3:0] n;
        r = '1;
        seen = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            n = v[4*k +: 4];
            if (b)
                r[7*k +: 7] = 7'h7F;
            else if (LZ && k != 0 && n == 4'h0 && !seen)
                r[7*k +: 7] = 7'h7F;
            else
                r[7*k +: 7] = SEG[n];
            if (n != 4'h0) seen = 1'b1;
        end
        return r;
    endfunction

    // Called at the #1-after-edge phase; returns at the sample after the accept edge.
    task automatic send(input logic [4*N-1:0] v, input logic b,
                        output int n);
        in_value = v;
        in_blank = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(model(v, b));
    endtask

    task automatic expect_commit(input bit tail);
        logic [W-1:0] e;
        for (int i = 0; i <= N; i++) begin
            chk("scan_busy", 64'(busy), 64'd1);
            chk("scan_ready", 64'(in_ready), 64'd0);
            chk("scan_hold", 64'(hex_out), 64'(shown));
            chk("scan_upd", 64'(update_done), 64'd0);
            @(posedge clk); #1;
        end
        chk("commit_upd", 64'(update_done), 64'd1);
        chk("commit_busy", 64'(busy), 64'd0);
        chk("commit_ready", 64'(in_ready), 64'd1);
        if (exp_q.size() == 0) begin
            chk("q_underflow", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("commit_hex", 64'(hex_out), 64'(e));
            shown = e;
        end
        if (tail) begin
            @(posedge clk); #1;
            chk("pulse_end", 64'(update_done), 64'd0);
            chk("hold_hex", 64'(hex_out), 64'(shown));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hex", 64'(hex_out), 64'(DARK));
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_upd", 64'(update_done), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_hex", 64'(hex_out), 64'(DARK));
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        shown = DARK;

        send(24'h012345, 1'b0, waited);
        expect_commit(1'b1);
        chk("d5_lead", 64'(hex_out[41:35]), LZ ? 64'h7F : 64'b1000000);
        chk("d0_five", 64'(hex_out[6:0]), 64'b0010010);

        send(24'h000000, 1'b0, waited);
        expect_commit(1'b1);
        chk("zero_d0", 64'(hex_out[6:0]), 64'b1000000);

        send(24'hABCDEF, 1'b1, waited);
        expect_commit(1'b1);
        chk("blank_all", 64'(hex_out), 64'(DARK));

        send(24'hFEDCBA, 1'b0, waited);
        expect_commit(1'b1);
        chk("d0_A", 64'(hex_out[6:0]), 64'b0001000);
        chk("d5_F", 64'(hex_out[41:35]), 64'b0001110);

        // second request held through the scan of the first
        send(24'h135790, 1'b0, waited);
        in_valid = 1'b1;
        in_value = 24'h2468AC;
        expect_commit(1'b0);
        send(24'h2468AC, 1'b0, waited);
        chk("acc_first_idle", 64'(waited), 64'd0);
        expect_commit(1'b1);

        // reset three cycles into a scan
        send(24'h777777, 1'b0, waited);
        repeat (2) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("midrst_hex", 64'(hex_out), 64'(DARK));
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        resetn = 1'b1;
        void'(exp_q.pop_front());
        shown = DARK;
        for (int i = 0; i < N + 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_noupd", 64'(update_done), 64'd0);
            chk("midrst_dark", 64'(hex_out), 64'(DARK));
        end

        send(24'hC0FFEE, 1'b0, waited);
        expect_commit(1'b1);

        chk("q_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Sequencer that turns a packed multi-nibble value into seven-segment patterns for the board's HEX displays, such as iteration counts and coordinates from the Mandelbrot datapath. It uses one shared nibble-to-segment decoder, time-multiplexed across digits, one digit per cycle. Results build up in a shadow register and are committed to the outputs in a single cycle, so the displays never show a half-updated value. Upstream producers hand values over with a valid/ready handshake.

Parameters:
NUM_DIGITS, 6, number of hex digits / displays driven (1..8)

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
in_valid  input  1  producer has a value to display
in_ready  output  1  controller can accept a value this cycle
in_value  input  4*NUM_DIGITS  packed nibbles; digit k = in_value[4k+3:4k], digit 0 rightmost
in_blank  input  1  sampled with in_value; 1 = all displays dark
hex_out  output  7*NUM_DIGITS  committed segments; digit k = hex_out[7k+6:7k], active-low, bit 6 = segment g
busy  output  1  scan in progress (state != IDLE)
update_done  output  1  one-cycle pulse in the cycle after hex_out changes

Behaviour:
- One clock, clk. Reset is synchronous and active-low: resetn sampled low at a rising edge of clk resets the block.
- Decoder mapping (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Blank = 1111111.
- Reset values:
  - hex_out all 1s (all dark), update_done 0, busy 0.
  - State IDLE, so in_ready reads 1 in the first cycle after reset.
  - Shadow and latched value are cleared to 0.
- Reset mid-scan: the scan is abandoned, nothing is committed, and hex_out returns to all 1s.
- FSM:
  - IDLE:
    - in_ready = 1.
    - On in_valid && in_ready: latch in_value and in_blank, set idx = NUM_DIGITS-1, clear seen_nz, go to SCAN.
  - SCAN:
    - in_ready = 0.
    - Each cycle: nib = latched digit idx; shadow[idx] = decode(nib), or Blank if latched blank.
    - If idx == 0, go to COMMIT; otherwise idx decrements.
    - Digits are scanned MSB first. seen_nz is set once any nonzero nibble has been scanned.
  - COMMIT:
    - hex_out <= shadow, updating all digits in the same edge.
    - Go to IDLE.
    - update_done is registered and is 1 for exactly the cycle after the commit edge.
- Latency and throughput:
  - Handshake accepted at edge T; hex_out updates at edge T+NUM_DIGITS+1.
  - in_ready rises in that same cycle, so back-to-back acceptance gives a throughput of one value per NUM_DIGITS+2 cycles.
- Handshake rules:
  - in_valid held while in_ready is 0 is ignored; no value is queued.
  - The producer must hold in_value stable until it is accepted.
  - Changes to in_value after acceptance do not affect the scan in progress.
- hex_out holds its last committed value indefinitely between updates.
- NUM_DIGITS = 1: SCAN lasts one cycle; behaviour is otherwise identical.

Optional Feature:
Macro HEX_LEAD_ZERO_BLANK_EN.
- Defined: during SCAN, for idx != 0, a zero nibble seen while seen_nz = 0 is written as Blank. Digit 0 is always decoded, so a value of 0 shows a single "0".
- Undefined: every digit is decoded; leading zeros are shown; seen_nz logic is omitted.
- Timing and handshake are identical in both builds.

Test Plan:
1. Reset hold, then release:
   - hex_out = 42'h3FFFFFFFFFF; in_ready = 1, busy = 0, update_done = 0.
2. in_value = 24'h012345, in_blank = 0, accepted at edge T:
   - busy is 1 for the following 7 cycles.
   - hex_out changes only at T+7, to digits {5:0, 4:1, 3:2, 2:3, 1:4, 0:5} = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010.
   - update_done is a single 1-cycle pulse.
3. Same stimulus with HEX_LEAD_ZERO_BLANK_EN defined:
   - Digit 5 = 1111111; the others are as in scenario 2.
   - Value 24'h000000 shows only digit 0 = 1000000.
4. in_blank = 1 with in_value = 24'hABCDEF: after commit, hex_out is all 1s. Then in_value = 24'hFEDCBA with in_blank = 0:
   - Digit 0 = 0001000 (A), digit 5 = 0001110 (F).
5. A second in_valid is asserted during SCAN:
   - It is not accepted while in_ready = 0.
   - It is accepted in the first IDLE cycle after the commit.
   - The first value is displayed intact.
6. resetn is pulled low 3 cycles into a scan:
   - hex_out is all 1s after that edge and update_done never pulses.
   - A fresh transaction afterwards completes normally.
